// File: rtl/wc_io_bridge.sv
// rtl/wc_io_bridge.sv - pad-limited I/O bridge: deserialise input beats to core operand, serialise results to pads
module wc_io_bridge #(
    parameter int PIN_IN  = 10,
    parameter int PIN_OUT = 10,
    parameter int D_W     = 70,
    parameter int Z_W     = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIN_IN-1:0]  pin_in,
    input  logic               pin_in_vld,
    input  logic               pin_sync,
    output logic [D_W-1:0]     core_d,
    output logic               core_d_vld,
    input  logic [Z_W-1:0]     core_z,
    input  logic               core_z_vld,
    output logic [PIN_OUT-1:0] pin_out,
    output logic               pin_out_vld,
    output logic               pin_out_sof,
    input  logic               clr_err,
    output logic               err_sync,
    output logic               err_ovf
);
    localparam int IN_BEATS  = (D_W + PIN_IN - 1) / PIN_IN;
    localparam int OUT_BEATS = (Z_W + PIN_OUT - 1) / PIN_OUT;
    localparam int IC_W      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OC_W      = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int SH_W      = IN_BEATS * PIN_IN;
    localparam int SR_W      = OUT_BEATS * PIN_OUT;
    localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_BEATS - 1);
    localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_BEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [IC_W-1:0] in_cnt_q, in_cnt_d;
    logic [SH_W-1:0] shadow_q, shadow_d;
    logic [D_W-1:0]  core_d_q, core_d_d;
    logic            core_d_vld_q, core_d_vld_d;
    state_t          state_q, state_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic [OC_W-1:0] out_cnt_q, out_cnt_d;
    logic [Z_W-1:0]  hb_q, hb_d;
    logic            hb_full_q, hb_full_d;
    logic            err_sync_q, err_sync_d;
    logic            err_ovf_q, err_ovf_d;
    logic [IC_W-1:0] idx;
    logic            sync_set, ovf_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt_q     <= '0;
            shadow_q     <= '0;
            core_d_q     <= '0;
            core_d_vld_q <= 1'b0;
            state_q      <= IDLE;
            sr_q         <= '0;
            out_cnt_q    <= '0;
            hb_q         <= '0;
            hb_full_q    <= 1'b0;
            err_sync_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            shadow_q     <= shadow_d;
            core_d_q     <= core_d_d;
            core_d_vld_q <= core_d_vld_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            out_cnt_q    <= out_cnt_d;
            hb_q         <= hb_d;
            hb_full_q    <= hb_full_d;
            err_sync_q   <= err_sync_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    // A sync beat arriving mid-frame restarts assembly at slot 0.
    always_comb begin
        in_cnt_d     = in_cnt_q;
        shadow_d     = shadow_q;
        core_d_d     = core_d_q;
        core_d_vld_d = 1'b0;
        sync_set     = 1'b0;
        idx          = in_cnt_q;
        if (pin_in_vld) begin
            if (pin_sync && (in_cnt_q != '0)) begin
                sync_set = 1'b1;
                idx      = '0;
            end
            for (int k = 0; k < IN_BEATS; k++) begin
                if (idx == IC_W'(k)) shadow_d[k*PIN_IN +: PIN_IN] = pin_in;
            end
            if (idx == IN_LAST) begin
                in_cnt_d     = '0;
                core_d_d     = shadow_d[D_W-1:0];
                core_d_vld_d = 1'b1;
            end else begin
                in_cnt_d = idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        out_cnt_d = out_cnt_q;
        hb_d      = hb_q;
        hb_full_d = hb_full_q;
        ovf_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_z_vld) begin
                    sr_d      = SR_W'(core_z);
                    out_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (out_cnt_q == OUT_LAST) begin
                    out_cnt_d = '0;
                    if (hb_full_q) begin
                        // Held result takes over; a result arriving now still finds HB occupied.
                        sr_d      = SR_W'(hb_q);
                        hb_full_d = 1'b0;
                        ovf_set   = core_z_vld;
                    end else if (core_z_vld) begin
                        sr_d = SR_W'(core_z);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sr_d      = sr_q >> PIN_OUT;
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (core_z_vld) begin
                        if (hb_full_q) begin
                            ovf_set = 1'b1;
                        end else begin
                            hb_d      = core_z;
                            hb_full_d = 1'b1;
                        end
                    end
                end
            end
        endcase
        err_sync_d = sync_set | (err_sync_q & ~clr_err);
        err_ovf_d  = ovf_set | (err_ovf_q & ~clr_err);
    end

    assign core_d      = core_d_q;
    assign core_d_vld  = core_d_vld_q;
    assign pin_out_vld = (state_q == SHIFT);
    assign pin_out_sof = (state_q == SHIFT) && (out_cnt_q == '0);
    assign pin_out     = (state_q == SHIFT) ? sr_q[PIN_OUT-1:0] : '0;
    assign err_sync    = err_sync_q;
    assign err_ovf     = err_ovf_q;
endmodule
